ob_halfword_unpacker: RTL

- Sits downstream of the DDR DMA engine on the read path.
- Drains 32-bit words from the DDR output buffer FIFO and splits each word into two 16-bit fp16 elements.
- Presents the elements as a valid/ready stream to the convolution engine.
- A host/controller start pulse with an element count defines each transfer; a done pulse marks completion.

---
 rtl/ob_halfword_unpacker_if.sv | 27 ++
 rtl/ob_halfword_unpacker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ob_halfword_unpacker_if.sv
// Bundle of the unpacker's control, FIFO-side and stream-side signals.
// The slave modport is the unpacker; the master modport is its environment.
interface ob_halfword_unpacker_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             ob_re;
    logic [31:0]      ob_data;
    logic             ob_valid;
    logic             ob_empty;
    logic [15:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    modport slave (
        input  start, len, ob_data, ob_valid, ob_empty, out_ready,
        output ob_re, out_data, out_valid, busy, done
    );

    modport master (
        output start, len, ob_data, ob_valid, ob_empty, out_ready,
        input  ob_re, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/ob_halfword_unpacker.sv
// Output-buffer halfword unpacker: drains 32-bit words from the DDR output
// buffer FIFO and streams them as 16-bit fp16 elements to the conv engine.
// A two-entry word buffer plus a single outstanding read keeps the stream
// at one element per cycle while never fetching more words than needed.
module ob_halfword_unpacker #(
    parameter bit LOW_FIRST = 1'b1,
    parameter int LEN_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ob_halfword_unpacker_if.slave bus
);
    // One extra bit so len = 2^LEN_W-1 and its word count never wrap.
    localparam int CW = LEN_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [CW-1:0] r_len;
    logic [CW-1:0] r_words_needed;
    logic [CW-1:0] r_req_cnt;
    logic [CW-1:0] r_elem_cnt;

    logic [31:0]   r_buf [2];
    logic          r_head;
    logic [1:0]    r_count;
    logic          r_half;
    logic          r_pending;

    logic [CW-1:0] w_len_ext;
    logic [CW-1:0] w_elem_inc;
    logic          w_start_ok;
    logic          w_room;
    logic          w_issue;
    logic          w_push;
    logic          w_hs;
    logic          w_last;
    logic          w_pop;
    logic          w_tail;
    logic          w_sel_upper;
    logic [31:0]   w_head_word;

    assign w_len_ext  = {1'b0, bus.len};
    assign w_elem_inc = r_elem_cnt + CW'(1);
    assign w_start_ok = (r_state == S_IDLE) && bus.start;

    // A read is only issued when its word is guaranteed a buffer slot.
    assign w_room  = ({1'b0, r_count} + {2'b00, r_pending}) < 3'd2;
    assign w_issue = (r_state == S_RUN) && !bus.ob_empty &&
                     (r_req_cnt < r_words_needed) && w_room && !r_pending;

    // Stray ob_valid without an outstanding read is dropped.
    assign w_push = bus.ob_valid && r_pending;

    assign w_hs   = (r_state == S_RUN) && (r_count != 2'd0) && bus.out_ready;
    assign w_last = (w_elem_inc == r_len);
    // The final element always frees its word, discarding an unused half.
    assign w_pop  = w_hs && (r_half || w_last);
    assign w_tail = r_head ^ r_count[0];

    assign w_head_word = r_buf[r_head];
    assign w_sel_upper = r_half ^ ~LOW_FIRST;

    assign bus.ob_re     = w_issue;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out_data  = w_sel_upper ? w_head_word[31:16] : w_head_word[15:0];
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a zero-length transfer goes straight to DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Transfer length, word target and progress counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len          <= '0;
            r_words_needed <= '0;
            r_req_cnt      <= '0;
            r_elem_cnt     <= '0;
        end else if (w_start_ok) begin
            r_len          <= w_len_ext;
            r_words_needed <= (w_len_ext + CW'(1)) >> 1;
            r_req_cnt      <= '0;
            r_elem_cnt     <= '0;
        end else begin
            if (w_issue) begin
                r_req_cnt <= r_req_cnt + CW'(1);
            end
            if (w_hs) begin
                r_elem_cnt <= w_elem_inc;
            end
        end
    end

    // Buffer bookkeeping: head pointer, occupancy, half-select, pending read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head    <= 1'b0;
            r_count   <= 2'd0;
            r_half    <= 1'b0;
            r_pending <= 1'b0;
        end else if (w_start_ok) begin
            r_head    <= 1'b0;
            r_count   <= 2'd0;
            r_half    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_issue || (r_pending && !bus.ob_valid);
            if (w_pop) begin
                r_head <= ~r_head;
                r_half <= 1'b0;
            end else if (w_hs) begin
                r_half <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Word storage: returning FIFO data lands in the tail slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_push) begin
            r_buf[w_tail] <= bus.ob_data;
        end
    end
endmodule
